// File: rtl/cycle_sequencer.sv
// Micro-cycle sequencer: drives the decoder's cycle index and reacts to the
// NEXT/HALT codes it returns, with single-step pause and overrun detection.
module cycle_sequencer #(
  parameter int          MAX_CYCLE  = 7,
  parameter int          CNT_W      = 16,
  parameter logic [3:0]  STATE_NEXT = 4'h1,
  parameter logic [3:0]  STATE_HALT = 4'h2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       state,
  input  logic             step_mode,
  input  logic             step,
  input  logic             resume,
  output logic [3:0]       cycle,
  output logic             halted,
  output logic             paused,
  output logic             instr_start,
  output logic [CNT_W-1:0] instr_count,
  output logic             seq_error
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    HALT  = 2'd2
  } fsm_t;

  localparam logic [3:0] LAST_CYCLE = 4'(MAX_CYCLE);

  fsm_t             fsm_q, fsm_d;
  logic [3:0]       cycle_q, cycle_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             start_q, start_d;

  // start_q marks that the current RUN clock at cycle 0 begins a new instruction
  // (as opposed to the restart after an overrun).
  always_comb begin
    fsm_d   = fsm_q;
    cycle_d = cycle_q;
    count_d = count_q;
    err_d   = err_q;
    start_d = 1'b0;
    case (fsm_q)
      RUN: begin
        if (state == STATE_HALT) begin
          fsm_d = HALT;
        end else if (state == STATE_NEXT) begin
          cycle_d = 4'd0;
          count_d = count_q + CNT_W'(1);
          if (step_mode) begin
            fsm_d = PAUSE;
          end else begin
            start_d = 1'b1;
          end
        end else if (cycle_q == LAST_CYCLE) begin
          err_d   = 1'b1;
          cycle_d = 4'd0;
        end else begin
          cycle_d = cycle_q + 4'd1;
        end
      end
      PAUSE: begin
        cycle_d = 4'd0;
        if (step || !step_mode) begin
          fsm_d   = RUN;
          start_d = 1'b1;
        end
      end
      HALT: begin
        if (resume) begin
          cycle_d = 4'd0;
          if (step_mode) begin
            fsm_d = PAUSE;
          end else begin
            fsm_d   = RUN;
            start_d = 1'b1;
          end
        end
      end
      default: begin
        fsm_d   = RUN;
        cycle_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= step_mode ? PAUSE : RUN;
      cycle_q <= 4'd0;
      count_q <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b1;
    end else begin
      fsm_q   <= fsm_d;
      cycle_q <= cycle_d;
      count_q <= count_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  assign cycle       = cycle_q;
  assign halted      = (fsm_q == HALT);
  assign paused      = (fsm_q == PAUSE);
  assign instr_start = start_q && (fsm_q == RUN) && !rst;
  assign instr_count = count_q;
  assign seq_error   = err_q;

endmodule
